// File: rtl/clint_mh_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clint_mh_pkg
// Description : Shared constants for the multi-hart core-local interruptor:
//               register offsets, per-hart strides, word-address helpers and
//               reset values.
// Revision    : 1.0 - initial release
// ============================================================================
package clint_mh_pkg;

  localparam int MSIP_OFS     = 'h0000;
  localparam int MSIP_STRIDE  = 4;
  localparam int MTCMP_OFS    = 'h4000;
  localparam int MTCMP_STRIDE = 8;
  localparam int MTDIV_OFS    = 'hBFF0;
  localparam int MTIME_OFS    = 'hBFF8;

  localparam logic [63:0] MTIMECMP_RST = '1;

  // Byte offset to word address (addr[23:2]); the low two address bits are
  // not part of the decode.
  function automatic logic [21:0] word_of(int ofs);
    return 22'(ofs >> 2);
  endfunction

  localparam logic [21:0] MTDIV_W = word_of(MTDIV_OFS);
  localparam logic [21:0] MTLO_W  = word_of(MTIME_OFS);
  localparam logic [21:0] MTHI_W  = word_of(MTIME_OFS + 4);

endpackage
`default_nettype wire

// File: rtl/clint_mh_if.sv
`default_nettype none
// ============================================================================
// Module      : clint_mh_if
// Description : LSU SRAM-style load/store port toward the CLINT.
//   lr_sram_cs/we/addr/wdata : access strobe, direction, byte address, data
//   clint_rdat               : read data, one cycle after the access
//   clint_cs_ff              : block select delayed one cycle
// Revision    : 1.0 - initial release
// ============================================================================
interface clint_mh_if;
  logic        lr_sram_cs;
  logic        lr_sram_we;
  logic [31:0] lr_sram_addr;
  logic [31:0] lr_sram_wdata;
  logic [31:0] clint_rdat;
  logic        clint_cs_ff;

  modport master (
    output lr_sram_cs, lr_sram_we, lr_sram_addr, lr_sram_wdata,
    input  clint_rdat, clint_cs_ff
  );

  modport slave (
    input  lr_sram_cs, lr_sram_we, lr_sram_addr, lr_sram_wdata,
    output clint_rdat, clint_cs_ff
  );
endinterface
`default_nettype wire

// File: rtl/clint_mh_hart.sv
`default_nettype none
// ============================================================================
// Module      : clint_hart
// Description : Per-hart slice of the CLINT: msip bit, 64-bit mtimecmp and
//               the registered timer compare against the shared mtime.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : decoded write to this block
//   word       : word address addr[23:2]
//   wdata      : write data
//   mtime      : shared machine timer
//   timer_int  : registered mtime >= mtimecmp
//   soft_int   : msip bit
//   rword      : read word for this hart's registers, 0 when not addressed
// Revision    : 1.0 - initial release
// ============================================================================
module clint_hart
  import clint_mh_pkg::*;
#(
  parameter int HART_ID = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [21:0] word,
  input  logic [31:0] wdata,
  input  logic [63:0] mtime,
  output logic        timer_int,
  output logic        soft_int,
  output logic [31:0] rword
);

  localparam logic [21:0] MSIP_W  = word_of(MSIP_OFS + MSIP_STRIDE * HART_ID);
  localparam logic [21:0] CMPLO_W = word_of(MTCMP_OFS + MTCMP_STRIDE * HART_ID);
  localparam logic [21:0] CMPHI_W = word_of(MTCMP_OFS + MTCMP_STRIDE * HART_ID + 4);

  logic        msip;
  logic [63:0] mtimecmp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msip      <= 1'b0;
      mtimecmp  <= MTIMECMP_RST;
      timer_int <= 1'b0;
    end else begin
      if (wr_en && word == MSIP_W)  msip            <= wdata[0];
      if (wr_en && word == CMPLO_W) mtimecmp[31:0]  <= wdata;
      if (wr_en && word == CMPHI_W) mtimecmp[63:32] <= wdata;
      // Compares the register value, so a new mtimecmp takes effect on the
      // interrupt one edge after it lands.
      timer_int <= (mtime >= mtimecmp);
    end
  end

  assign soft_int = msip;

  always_comb begin
    rword = '0;
    case (word)
      MSIP_W:  rword = {31'b0, msip};
      CMPLO_W: rword = mtimecmp[31:0];
      CMPHI_W: rword = mtimecmp[63:32];
      default: rword = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/clint_mh.sv
`default_nettype none
// ============================================================================
// Module      : clint_mh
// Description : Multi-hart core-local interruptor. Shared 64-bit mtime with
//               programmable prescaler, per-hart msip/mtimecmp slices, and a
//               one-cycle-latency read path on the LSU SRAM port.
//   clk       : core clock
//   cpurst_n  : asynchronous active-low reset
//   bus       : LSU access port (slave side)
//   timer_int : per-hart machine timer interrupt (registered)
//   soft_int  : per-hart machine software interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module clint_mh
  import clint_mh_pkg::*;
#(
  parameter int          NHART   = 1,
  parameter logic [7:0]  BASE    = 8'h02,
  parameter int          DIVW    = 8,
  parameter bit          SNAP_EN = 1'b1
) (
  input  logic             clk,
  input  logic             cpurst_n,
  clint_mh_if.slave        bus,
  output logic [NHART-1:0] timer_int,
  output logic [NHART-1:0] soft_int
);

  logic            clint_cs;
  logic            wr_en;
  logic            rd_en;
  logic [21:0]     word;
  logic            unused_addr_bits;

  logic [DIVW-1:0] mtime_div;
  logic [DIVW-1:0] cnt;
  logic            tick;
  logic [63:0]     mtime;
  logic [31:0]     snap;
  logic [31:0]     rmux;
  logic [31:0]     rdat_q;
  logic            cs_q;
  logic [31:0]     hart_rword [NHART];

  assign clint_cs         = bus.lr_sram_cs && (bus.lr_sram_addr[31:24] == BASE);
  assign wr_en            = clint_cs && bus.lr_sram_we;
  assign rd_en            = clint_cs && !bus.lr_sram_we;
  assign word             = bus.lr_sram_addr[23:2];
  assign unused_addr_bits = ^bus.lr_sram_addr[1:0];

  assign tick = (cnt == mtime_div);

  // Prescaler: one mtime increment every mtime_div+1 cycles.
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      mtime_div <= '0;
      cnt       <= '0;
    end else if (wr_en && word == MTDIV_W) begin
      mtime_div <= bus.lr_sram_wdata[DIVW-1:0];
      cnt       <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIVW'(1);
    end
  end

  // A software write to either half replaces it and drops that cycle's
  // increment entirely, so no carry crosses into the untouched half.
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      mtime <= '0;
    end else if (wr_en && word == MTLO_W) begin
      mtime[31:0] <= bus.lr_sram_wdata;
    end else if (wr_en && word == MTHI_W) begin
      mtime[63:32] <= bus.lr_sram_wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // Capture the upper half alongside a low-half read so a following hi read
  // is coherent even if a carry happened in between.
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      snap <= '0;
    end else if (rd_en && word == MTLO_W) begin
      snap <= mtime[63:32];
    end
  end

  for (genvar h = 0; h < NHART; h++) begin : g_hart
    clint_hart #(
      .HART_ID (h)
    ) u_hart (
      .clk       (clk),
      .rst_n     (cpurst_n),
      .wr_en     (wr_en),
      .word      (word),
      .wdata     (bus.lr_sram_wdata),
      .mtime     (mtime),
      .timer_int (timer_int[h]),
      .soft_int  (soft_int[h]),
      .rword     (hart_rword[h])
    );
  end

  // Hart slices return zero unless addressed, so OR-ing them is the mux.
  always_comb begin
    rmux = '0;
    case (word)
      MTDIV_W: rmux = 32'(mtime_div);
      MTLO_W:  rmux = mtime[31:0];
      MTHI_W:  rmux = SNAP_EN ? snap : mtime[63:32];
      default: begin
        for (int h = 0; h < NHART; h++) rmux = rmux | hart_rword[h];
      end
    endcase
  end

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      rdat_q <= '0;
      cs_q   <= 1'b0;
    end else begin
      rdat_q <= rd_en ? rmux : 32'h0;
      cs_q   <= clint_cs;
    end
  end

  assign bus.clint_rdat  = rdat_q;
  assign bus.clint_cs_ff = cs_q;

endmodule
`default_nettype wire

// File: tb/tb_clint_mh.sv
`default_nettype none
// ============================================================================
// Module      : tb_clint_mh
// Description : Self-checking bench for clint_mh. Two instances (coherent
//               and live mtime_hi reads) share one stimulus stream and are
//               checked every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clint_mh;

  localparam int NH = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        cs    = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;

  always #5 clk = ~clk;

  clint_mh_if bus0 ();
  clint_mh_if bus1 ();

  assign bus0.lr_sram_cs    = cs;
  assign bus0.lr_sram_we    = we;
  assign bus0.lr_sram_addr  = addr;
  assign bus0.lr_sram_wdata = wdata;
  assign bus1.lr_sram_cs    = cs;
  assign bus1.lr_sram_we    = we;
  assign bus1.lr_sram_addr  = addr;
  assign bus1.lr_sram_wdata = wdata;

  logic [NH-1:0] ti0, si0, ti1, si1;

  clint_mh #(.NHART(NH), .BASE(8'h02), .DIVW(8), .SNAP_EN(1'b1)) dut0 (
    .clk(clk), .cpurst_n(rst_n), .bus(bus0), .timer_int(ti0), .soft_int(si0)
  );
  clint_mh #(.NHART(NH), .BASE(8'h02), .DIVW(8), .SNAP_EN(1'b0)) dut1 (
    .clk(clk), .cpurst_n(rst_n), .bus(bus1), .timer_int(ti1), .soft_int(si1)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0]   m_time;
  int            m_cnt;
  int            m_div;
  logic [NH-1:0] m_msip;
  logic [63:0]   m_cmp [NH];
  logic [31:0]   m_snap;
  logic [NH-1:0] e_ti;
  logic [31:0]   e_rd0, e_rd1;
  logic          e_csff;

  function automatic bit sel_now();
    return cs && (addr[31:24] == 8'h02);
  endfunction
  function automatic bit wr_now();
    return sel_now() && we;
  endfunction
  function automatic bit rd_now();
    return sel_now() && !we;
  endfunction
  function automatic int off_now();
    return int'({8'd0, addr[23:2], 2'b00});
  endfunction
  function automatic bit is_cmp(int off);
    return off >= 'h4000 && off < 'h4000 + 8 * NH;
  endfunction

  function automatic logic [31:0] peek(int off, bit snap_en);
    if (off < 4 * NH) return {31'b0, m_msip[off / 4]};
    if (is_cmp(off)) begin
      if (off % 8 == 0) return m_cmp[(off - 'h4000) / 8][31:0];
      return m_cmp[(off - 'h4000) / 8][63:32];
    end
    if (off == 'hBFF0) return 32'(m_div);
    if (off == 'hBFF8) return m_time[31:0];
    if (off == 'hBFFC) return snap_en ? m_snap : m_time[63:32];
    return 32'h0;
  endfunction

  function automatic logic [63:0] next_time();
    logic [63:0] t;
    t = (m_cnt == m_div) ? m_time + 64'd1 : m_time;
    if (wr_now() && off_now() == 'hBFF8) t = {m_time[63:32], wdata};
    if (wr_now() && off_now() == 'hBFFC) t = {wdata, m_time[31:0]};
    return t;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_time <= '0;
      m_cnt  <= 0;
      m_div  <= 0;
      m_msip <= '0;
      m_snap <= '0;
      for (int h = 0; h < NH; h++) m_cmp[h] <= '1;
      e_ti   <= '0;
      e_rd0  <= '0;
      e_rd1  <= '0;
      e_csff <= 1'b0;
    end else begin
      for (int h = 0; h < NH; h++) e_ti[h] <= (m_time >= m_cmp[h]);
      e_csff <= sel_now();
      e_rd0  <= rd_now() ? peek(off_now(), 1'b1) : 32'h0;
      e_rd1  <= rd_now() ? peek(off_now(), 1'b0) : 32'h0;
      m_time <= next_time();
      if (wr_now() && off_now() == 'hBFF0) begin
        m_div <= int'(wdata[7:0]);
        m_cnt <= 0;
      end else begin
        m_cnt <= (m_cnt == m_div) ? 0 : m_cnt + 1;
      end
      if (rd_now() && off_now() == 'hBFF8) m_snap <= m_time[63:32];
      if (wr_now() && off_now() < 4 * NH) m_msip[off_now() / 4] <= wdata[0];
      if (wr_now() && is_cmp(off_now()))
        m_cmp[(off_now() - 'h4000) / 8] <= (off_now() % 8 == 0)
          ? {m_cmp[(off_now() - 'h4000) / 8][63:32], wdata}
          : {wdata, m_cmp[(off_now() - 'h4000) / 8][31:0]};
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dut0.timer_int", 64'(ti0), 64'(e_ti));
      chk("dut1.timer_int", 64'(ti1), 64'(e_ti));
      chk("dut0.soft_int", 64'(si0), 64'(m_msip));
      chk("dut1.soft_int", 64'(si1), 64'(m_msip));
      chk("dut0.clint_rdat", 64'(bus0.clint_rdat), 64'(e_rd0));
      chk("dut1.clint_rdat", 64'(bus1.clint_rdat), 64'(e_rd1));
      chk("dut0.clint_cs_ff", 64'(bus0.clint_cs_ff), 64'(e_csff));
      chk("dut1.clint_cs_ff", 64'(bus1.clint_cs_ff), 64'(e_csff));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(bit c, bit w, logic [31:0] a, logic [31:0] d);
    @(posedge clk);
    #2;
    cs = c; we = w; addr = a; wdata = d;
  endtask
  task automatic wr(logic [31:0] a, logic [31:0] d);
    drive(1'b1, 1'b1, a, d);
  endtask
  task automatic rd(logic [31:0] a);
    drive(1'b1, 1'b0, a, 32'h0);
  endtask
  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // reset state
    idle();
    chk("reset timer_int", 64'(ti0), 64'h0);
    chk("reset soft_int", 64'(si0), 64'h0);
    rd(32'h0200_4000);
    rd(32'h0200_4004);
    chk("mtimecmp0 lo reset", 64'(bus0.clint_rdat), 64'hFFFF_FFFF);
    idle();
    chk("mtimecmp0 hi reset", 64'(bus0.clint_rdat), 64'hFFFF_FFFF);

    // msip
    wr(32'h0200_0008, 32'hFFFF_FFFF);
    idle();
    chk("soft_int after msip2", 64'(si0), 64'h4);
    rd(32'h0200_0008);
    idle();
    chk("msip2 read", 64'(bus0.clint_rdat), 64'h1);
    rd(32'h0200_0010);
    idle();
    chk("msip4 unmapped", 64'(bus0.clint_rdat), 64'h0);
    rd(32'h0300_4000);
    idle();
    chk("wrong base rdat", 64'(bus0.clint_rdat), 64'h0);
    chk("wrong base cs_ff", 64'(bus0.clint_cs_ff), 64'h0);

    // prescaler, div=3
    wr(32'h0200_BFF0, 32'd3);
    wr(32'h0200_BFF8, 32'd0);
    wr(32'h0200_BFFC, 32'd0);
    idle();
    rd(32'h0200_BFF8);
    rd(32'h0200_BFF8);
    chk("presc read a", 64'(bus0.clint_rdat), 64'd0);
    idle();
    chk("presc read b", 64'(bus0.clint_rdat), 64'd1);
    idle();
    rd(32'h0200_BFF8);
    rd(32'h0200_BFF8);
    chk("presc read c", 64'(bus0.clint_rdat), 64'd1);
    idle();
    chk("presc read d", 64'(bus0.clint_rdat), 64'd2);

    // hart 1 timer at 0x10
    wr(32'h0200_4008, 32'h10);
    wr(32'h0200_400C, 32'h0);
    for (int i = 0; i < 200 && !ti0[1]; i++) idle();
    chk("timer_int1 rise within bound", 64'(ti0[1]), 64'h1);
    chk("timer_int only hart1", 64'(ti0), 64'h2);
    rd(32'h0200_BFF8);
    idle();
    chk("mtime at timer rise", 64'(bus0.clint_rdat), 64'h10);

    // snapshot across a carry
    wr(32'h0200_BFF0, 32'd0);
    wr(32'h0200_BFF8, 32'd0);
    wr(32'h0200_BFFC, 32'd0);
    wr(32'h0200_BFF8, 32'hFFFF_FFFE);
    idle();
    rd(32'h0200_BFF8);
    rd(32'h0200_BFFC);
    chk("snap lo read", 64'(bus0.clint_rdat), 64'hFFFF_FFFF);
    idle();
    chk("snap hi coherent", 64'(bus0.clint_rdat), 64'h0);
    chk("snap hi live", 64'(bus1.clint_rdat), 64'h1);

    // mtime wrap, hart 3 compare = 5
    wr(32'h0200_4018, 32'd5);
    wr(32'h0200_401C, 32'd0);
    wr(32'h0200_BFFC, 32'hFFFF_FFFF);
    wr(32'h0200_BFF8, 32'hFFFF_FFFF);
    idle();
    idle();
    chk("timer_int at all-ones", 64'(ti0), 64'hF);
    idle();
    chk("timer_int after wrap", 64'(ti0), 64'h0);
    chk("timer_int after wrap dut1", 64'(ti1), 64'h0);

    // async reset mid-access with timer_int asserted
    repeat (8) idle();
    rd(32'h0200_4000);
    rd(32'h0200_BFF8);
    chk("pre-reset rdat", 64'(bus0.clint_rdat), 64'hFFFF_FFFF);
    chk("pre-reset timer_int3", 64'(ti0[3]), 64'h1);
    chk("pre-reset cs_ff", 64'(bus0.clint_cs_ff), 64'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst timer_int", 64'(ti0), 64'h0);
    chk("async rst soft_int", 64'(si0), 64'h0);
    chk("async rst rdat", 64'(bus0.clint_rdat), 64'h0);
    chk("async rst cs_ff", 64'(bus0.clint_cs_ff), 64'h0);
    chk("async rst dut1 timer_int", 64'(ti1), 64'h0);
    chk("async rst dut1 rdat", 64'(bus1.clint_rdat), 64'h0);
    cs = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    rd(32'h0200_4004);
    idle();
    chk("post-reset cmp hi", 64'(bus0.clint_rdat), 64'hFFFF_FFFF);
    idle();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
